// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_arbiter
// Description : Two-requester round-robin arbiter and sequencer for a shared
//               register bank. It serialises write, constant-load and read
//               transactions and returns read-back data with a one-cycle ack.
//               Optional macro REG_ACCESS_LOCK_EN adds lock_a/lock_b inputs
//               that let a requester keep exclusive ownership across
//               transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   SD_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [1:0]       op_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
`ifdef REG_ACCESS_LOCK_EN
    input  logic             lock_a,
    input  logic             lock_b,
`endif
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             reg_en,
    output logic             reg_sln,
    output logic [WIDTH-1:0] reg_d,
    output logic [WIDTH-1:0] reg_sd,
    input  logic [WIDTH-1:0] reg_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;       // 0 = A, 1 = B
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic               r_last_grant;  // 0 = A, 1 = B
    logic               w_grant;
    logic               w_grant_b;
    logic               w_in_issue;

`ifdef REG_ACCESS_LOCK_EN
    logic               r_locked;
    logic               w_owner_lock;

    assign w_owner_lock = r_owner ? lock_b : lock_a;
`endif

    // Grant decision in IDLE: a locked owner is the only candidate, otherwise
    // a single requester wins outright and a tie goes away from last_grant.
    always_comb begin
        w_grant   = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == S_IDLE) begin
`ifdef REG_ACCESS_LOCK_EN
            if (r_locked) begin
                w_grant   = r_owner ? req_b : req_a;
                w_grant_b = r_owner;
            end else
`endif
            if (req_a && req_b) begin
                w_grant   = 1'b1;
                w_grant_b = ~r_last_grant;
            end else if (req_a || req_b) begin
                w_grant   = 1'b1;
                w_grant_b = req_b;
            end
        end
    end

    // Next-state logic: IDLE waits for a grant, ISSUE and ACK last one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus the owner, op and data captured at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_op         <= 2'b00;
            r_data       <= '0;
            r_last_grant <= 1'b1;
`ifdef REG_ACCESS_LOCK_EN
            r_locked     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_b;
                r_op    <= w_grant_b ? op_b   : op_a;
                r_data  <= w_grant_b ? data_b : data_a;
`ifndef REG_ACCESS_LOCK_EN
                r_last_grant <= w_grant_b;
`endif
            end
`ifdef REG_ACCESS_LOCK_EN
            // Fairness history only moves when the owner releases its lock.
            if (r_state == S_ACK) begin
                if (w_owner_lock) begin
                    r_locked <= 1'b1;
                end else begin
                    r_locked     <= 1'b0;
                    r_last_grant <= r_owner;
                end
            end
`endif
        end
    end

    assign w_in_issue = (r_state == S_ISSUE);

    // Bank controls are only active in ISSUE; reads leave the bank untouched.
    always_comb begin
        reg_en  = w_in_issue && !r_op[1];
        reg_sln = !(w_in_issue && (r_op == c_OP_LOAD));
        reg_d   = (w_in_issue && (r_op == c_OP_WRITE)) ? r_data : '0;
    end

    // Ack is suppressed while reset is asserted so an aborted transaction
    // never reports completion.
    always_comb begin
        ack_a = (r_state == S_ACK) && !r_owner && !rst;
        ack_b = (r_state == S_ACK) &&  r_owner && !rst;
        rdata = (ack_a || ack_b) ? reg_q : '0;
        busy  = (r_state != S_IDLE);
    end

    assign reg_sd = SD_VALUE;

endmodule
`default_nettype wire
